// File: rtl/sync_ram_256x32_if.sv
// Bus interface for the 256x32 single-port synchronous RAM.
// The master drives the access controls and write data; the slave returns registered read data.
interface sync_ram_256x32_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  cen;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output cen,
        output wen,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  cen,
        input  wen,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/sync_ram_256x32.sv
// Single-port synchronous RAM, 256 x 32, one-cycle registered read.
// Storage is a flip-flop array so that reset can clear every word asynchronously.
module sync_ram_256x32 #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    sync_ram_256x32_if.slave   bus
);

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("sync_ram_256x32: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic [DATA_WIDTH-1:0]            r_dout;

    logic w_wr_en;
    logic w_rd_en;

    assign w_wr_en = bus.cen &  bus.wen;
    assign w_rd_en = bus.cen & ~bus.wen;

    // NOTE: the whole array sits in the async-reset branch because every word must
    // read back as zero after reset; this rules out mapping onto a block RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.addr] <= bus.din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the read below samples
    // the array as it was before this edge's write, independent of block ordering.
    // Writes and idle cycles drive zero so stale data never lingers on the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= '0;
        end else if (w_rd_en) begin
            r_dout <= r_mem[bus.addr];
        end else begin
            r_dout <= '0;
        end
    end

    assign bus.dout = r_dout;

endmodule

// File: tb/tb_sync_ram_256x32.sv
// Self-checking bench for sync_ram_256x32: directed sequences, a vector table and
// randomized traffic compared against an array-based model of the memory.
module tb_sync_ram_256x32;

    logic clk;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [256];

    typedef struct {
        logic        cen;
        logic        wen;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [10];

    sync_ram_256x32_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    sync_ram_256x32 #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: dout=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    endtask

    // One access: drive on the falling edge, let the rising edge act, check just after it.
    task automatic step(input logic cen, input logic wen, input logic [7:0] addr,
                        input logic [31:0] din, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.cen  = cen;
        bus.wen  = wen;
        bus.addr = addr;
        bus.din  = din;
        @(posedge clk);
        if (cen && wen) model_mem[addr] = din;
        #1;
        check(name, bus.dout, exp);
    endtask

    function automatic logic [31:0] model_expect(input logic cen, input logic wen, input logic [7:0] addr);
        return (cen && !wen) ? model_mem[addr] : 32'h0;
    endfunction

    initial begin
        logic        r_cen, r_wen;
        logic [7:0]  r_addr;
        logic [31:0] r_din;

        vecs[0] = '{1'b1, 1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 8'h00, 32'hA5A5_A5A5, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 32'h0,         32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 32'h0,         32'hA5A5_A5A5};
        vecs[4] = '{1'b1, 1'b1, 8'h40, 32'h1234_5678, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 8'h40, 32'h0,         32'h1234_5678};
        vecs[6] = '{1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 8'h05, 32'h0,         32'h0000_0005};
        vecs[8] = '{1'b0, 1'b0, 8'h11, 32'h5555_5555, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 8'h1F, 32'h0,         32'h0000_001F};

        clear_model();

        // Reset held with random inputs, including write attempts that must not land.
        reset_n  = 1'b0;
        bus.cen  = 1'b1;
        bus.wen  = 1'b1;
        bus.addr = 8'h00;
        bus.din  = $urandom;
        #1;
        check("reset_async_dout", bus.dout, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.cen  = 1'b1;
            bus.wen  = (i < 2);
            bus.addr = (i % 2 == 0) ? 8'h00 : 8'hFF;
            bus.din  = $urandom | 32'h1;
            @(posedge clk);
            #1;
            check("reset_hold_dout", bus.dout, 32'h0);
        end
        @(negedge clk);
        bus.cen = 1'b0;
        bus.wen = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 8'h00, 32'h0, 32'h0, "post_reset_read_00");
        step(1'b1, 1'b0, 8'hFF, 32'h0, 32'h0, "post_reset_read_ff");

        // Sequential write then sweep read, each write cycle must show zero.
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b1, 8'(i), 32'(i), 32'h0, "seq_write_dout_zero");
        step(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, "seq_idle");
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b0, 8'(i), 32'h0, 32'(i), "seq_read");
        step(1'b1, 1'b0, 8'h00, 32'h0, 32'h0, "seq_read_wrap_00");

        // Table: boundaries, write-then-read, idle protection.
        for (int i = 0; i < 10; i++)
            step(vecs[i].cen, vecs[i].wen, vecs[i].addr, vecs[i].din, vecs[i].exp_dout,
                 $sformatf("vec%0d", i));

        // Randomized traffic against the array model.
        for (int i = 0; i < 400; i++) begin
            r_cen  = ($urandom_range(0, 3) != 0);
            r_wen  = $urandom_range(0, 1) == 1;
            r_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 15));
            r_din  = $urandom;
            step(r_cen, r_wen, r_addr, r_din, model_expect(r_cen, r_wen, r_addr), "random");
        end

        // Async reset in the middle of a read sweep.
        step(1'b1, 1'b1, 8'h03, 32'hCAFE_F00D, 32'h0, "pre_reset_write_03");
        step(1'b1, 1'b0, 8'h02, 32'h0, model_expect(1'b1, 1'b0, 8'h02), "sweep_02");
        step(1'b1, 1'b0, 8'h03, 32'h0, 32'hCAFE_F00D, "sweep_03");
        bus.addr = 8'h04;
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        check("midstream_reset_async_dout", bus.dout, 32'h0);
        @(posedge clk);
        #1;
        check("midstream_reset_hold_dout", bus.dout, 32'h0);
        @(negedge clk);
        bus.cen = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 8'h03, 32'h0, 32'h0, "post_reset_read_03");
        step(1'b1, 1'b0, 8'h40, 32'h0, 32'h0, "post_reset_read_40");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
